serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: one difference bit per clock, LSB first, with a registered borrow.
// Optional add mode (in_op port) when SERIAL_SUB_ADD_MODE_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_borrow,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             in_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready/out_valid depend only on the state register.
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [CW-1:0]    cnt;
    logic             bor;
    logic             d_bit;
    logic             bor_next;
    logic             d1;
    logic             b1;
    logic             b2;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             op_r;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Two cascaded half-subtractors; add mode swaps in a full adder on the same registers.
    always_comb begin
        d1       = a_sr[0] ^ b_sr[0];
        b1       = ~a_sr[0] & b_sr[0];
        b2       = ~d1 & bor;
        d_bit    = d1 ^ bor;
        bor_next = b1 | b2;
`ifdef SERIAL_SUB_ADD_MODE_EN
        if (op_r) begin
            d_bit    = a_sr[0] ^ b_sr[0] ^ bor;
            bor_next = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & bor);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            cnt        <= '0;
            bor        <= 1'b0;
            out_diff   <= '0;
            out_borrow <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_r       <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= in_a;
                        b_sr <= in_b;
                        bor  <= in_borrow;
                        cnt  <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                        op_r <= in_op;
`endif
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
                    bor     <= bor_next;
                    if (cnt == LAST) begin
                        out_diff   <= {d_bit, diff_sr[WIDTH-1:1]};
                        out_borrow <= bor_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8); covers add mode when SERIAL_SUB_ADD_MODE_EN is defined.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_borrow = 1'b0;
    logic             in_op = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    logic             busy;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_borrow(in_borrow),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .in_op(in_op),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_diff(out_diff), .out_borrow(out_borrow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge, then wait (bounded) for out_valid.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic op);
        in_a = a; in_b = b; in_borrow = bi; in_op = op; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_borrow = ~bi;
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(WIDTH));
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic op, input logic [7:0] exp_d, input logic exp_b);
        int lat;
        start_op(a, b, bi, op);
        wait_done(tag, lat);
        check({tag, "_diff"}, 64'(out_diff), 64'(exp_d));
        check({tag, "_borrow"}, 64'(out_borrow), 64'(exp_b));
        check({tag, "_done_flags"}, {61'd0, out_valid, in_ready, busy}, 64'b101);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_flags"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
        check({tag, "_held_diff"}, 64'(out_diff), 64'(exp_d));
        check({tag, "_held_borrow"}, 64'(out_borrow), 64'(exp_b));
    endtask

    initial begin
        int lat;
        // Reset state
        #2;
        check("rst_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);
        check("rst_diff", 64'(out_diff), 64'h0);
        check("rst_borrow", 64'(out_borrow), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", {61'd0, out_valid, in_ready, busy}, 64'b010);

        // Directed subtract vectors
        run_op("basic",     8'h5A, 8'h3C, 1'b0, 1'b0, 8'h1E, 1'b0);
        run_op("underflow", 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1);
        run_op("borrow_in", 8'h10, 8'h10, 1'b1, 1'b0, 8'hFF, 1'b1);
        run_op("ff_minus1", 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFE, 1'b0);
        run_op("mid",       8'h80, 8'h7F, 1'b0, 1'b0, 8'h01, 1'b0);
        run_op("wrap_zero", 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1);
        run_op("equal",     8'hA5, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);

        // Backpressure: hold DONE, offer a new operation that must be ignored
        start_op(8'hC3, 8'h41, 1'b0, 1'b0);
        wait_done("bp", lat);
        in_a = 8'h11; in_b = 8'h22; in_borrow = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_ready", {62'd0, out_valid, in_ready}, 64'b10);
            check("bp_diff", 64'(out_diff), 64'h82);
            check("bp_borrow", 64'(out_borrow), 64'h0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", {61'd0, out_valid, in_ready, busy}, 64'b010);
        tick();
        check("bp_no_accept", {61'd0, out_valid, in_ready, busy}, 64'b010);
        check("bp_kept_diff", 64'(out_diff), 64'h82);

        // Reset during the third SHIFT cycle
        start_op(8'h37, 8'h12, 1'b0, 1'b0);
        tick();
        tick();
        check("pre_rst_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);
        check("mid_rst_diff", 64'(out_diff), 64'h0);
        check("mid_rst_borrow", 64'(out_borrow), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 64'(in_ready), 64'h1);
        run_op("fresh", 8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_SUB_ADD_MODE_EN
        run_op("add_carry", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
        run_op("add_cin",   8'h12, 8'h34, 1'b1, 1'b1, 8'h47, 1'b0);
        run_op("sub_again", 8'h12, 8'h34, 1'b1, 1'b0, 8'hDD, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
